uart_top: RTL and testbench

UART_TOP -- requirements
Module: uart_top

---
 rtl/uart_top.sv | 357 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_top.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// UART 8N1 receiver -> RX FIFO -> HD44780 8-bit LCD writer at 16x oversampling.
// Optional feature macro UART_ECHO_EN: each displayed byte is also retransmitted on tx.
module uart_top #(
  parameter int DATA_BITS         = 8,
  parameter int STOP_BIT_TICK     = 16,
  parameter int BR_LIMIT          = 326,
  parameter int BR_BITS           = 9,
  parameter int FIFO_EXP          = 4,
  parameter int LCD_INIT_CYCLES   = 1_000_000,
  parameter int LCD_ACCESS_CYCLES = 100_000,
  parameter int LCD_EN_CYCLES     = 25
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  output logic       rs,
  output logic       rw,
  output logic       enable,
  output logic [7:0] data_lcd,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic [5:0] o_dbg_state
);

  localparam int TW      = $clog2((STOP_BIT_TICK > 16) ? STOP_BIT_TICK : 16);
  localparam int NW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int DEPTH   = 1 << FIFO_EXP;
  localparam int LCD_MAX = (LCD_INIT_CYCLES > LCD_ACCESS_CYCLES) ? LCD_INIT_CYCLES : LCD_ACCESS_CYCLES;
  localparam int LCW     = $clog2(LCD_MAX);

  // ---------------------------------------------------------------- baud tick
  logic [BR_BITS-1:0] r_br_cnt;
  logic               w_tick;

  assign w_tick = (r_br_cnt == BR_BITS'(BR_LIMIT - 1));

  always_ff @(posedge clk_50MHz) begin
    if (reset || w_tick) r_br_cnt <= '0;
    else                 r_br_cnt <= r_br_cnt + 1'b1;
  end

  // ---------------------------------------------------------------- rx synchroniser
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;
  logic w_rx_fall;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // A true falling edge is needed, so a line left low after a framing error cannot restart a frame.
  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t            r_rx_state;
  logic [TW-1:0]        r_rx_s;
  logic [NW-1:0]        r_rx_n;
  logic [DATA_BITS-1:0] r_rx_b;
  logic                 r_rx_done;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_s     <= '0;
      r_rx_n     <= '0;
      r_rx_b     <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= RX_START;
            r_rx_s     <= '0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_s == TW'(7)) begin
              r_rx_s <= '0;
              r_rx_n <= '0;
              if (r_rx_sync) r_rx_state <= RX_IDLE;
              else           r_rx_state <= RX_DATA;
            end else begin
              r_rx_s <= r_rx_s + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rx_s == TW'(15)) begin
              r_rx_s <= '0;
              r_rx_b <= {r_rx_sync, r_rx_b[DATA_BITS-1:1]};
              if (r_rx_n == NW'(DATA_BITS - 1)) r_rx_state <= RX_STOP;
              else                              r_rx_n     <= r_rx_n + 1'b1;
            end else begin
              r_rx_s <= r_rx_s + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_rx_s == TW'(STOP_BIT_TICK - 1)) begin
              r_rx_state <= RX_IDLE;
              r_rx_done  <= r_rx_sync;
            end else begin
              r_rx_s <= r_rx_s + 1'b1;
            end
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_EXP-1:0]  r_wptr;
  logic [FIFO_EXP-1:0]  r_rptr;
  logic [FIFO_EXP:0]    r_count;
  logic [FIFO_EXP:0]    w_count_nxt;
  logic                 w_pop;
  logic                 w_do_push;
  logic [DATA_BITS-1:0] w_pop_data;
  logic                 w_lcd_ready;
  logic                 w_tx_idle;

  // Pop handshake: valid = !fifo_empty, ready = LCD ready and transmitter idle;
  // the byte transfers in the single cycle where both are high, never otherwise.
  assign w_pop      = !fifo_empty && w_lcd_ready && w_tx_idle;
  assign w_do_push  = r_rx_done && (!fifo_full || w_pop);
  assign w_pop_data = r_mem[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_do_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk_50MHz) begin
    if (w_do_push) r_mem[r_wptr] <= r_rx_b;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count    <= w_count_nxt;
      fifo_full  <= (w_count_nxt == (FIFO_EXP + 1)'(DEPTH));
      fifo_empty <= (w_count_nxt == '0);
    end
  end

  // ---------------------------------------------------------------- echo transmitter
  logic [1:0] w_tx_dbg;

`ifdef UART_ECHO_EN
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t            r_tx_state;
  logic [3:0]           r_tx_s;
  logic [NW-1:0]        r_tx_n;
  logic [DATA_BITS-1:0] r_tx_b;
  logic                 r_tx;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx_b     <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_tx_b     <= w_pop_data;
            r_tx_s     <= '0;
            r_tx       <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tick) begin
            if (r_tx_s == 4'd15) begin
              r_tx_s     <= '0;
              r_tx_n     <= '0;
              r_tx       <= r_tx_b[0];
              r_tx_state <= TX_DATA;
            end else begin
              r_tx_s <= r_tx_s + 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_tx_s == 4'd15) begin
              r_tx_s <= '0;
              r_tx_b <= r_tx_b >> 1;
              if (r_tx_n == NW'(DATA_BITS - 1)) begin
                r_tx       <= 1'b1;
                r_tx_state <= TX_STOP;
              end else begin
                r_tx_n <= r_tx_n + 1'b1;
                r_tx   <= r_tx_b[1];
              end
            end else begin
              r_tx_s <= r_tx_s + 1'b1;
            end
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (r_tx_s == 4'd15) r_tx_state <= TX_IDLE;
            else                 r_tx_s     <= r_tx_s + 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx        = r_tx;
  assign w_tx_idle = (r_tx_state == TX_IDLE);
  assign w_tx_dbg  = r_tx_state;
`else
  assign tx        = 1'b1;
  assign w_tx_idle = 1'b1;
  assign w_tx_dbg  = 2'b00;
`endif

  // ---------------------------------------------------------------- LCD controller
  typedef enum logic [1:0] {LCD_POWERUP, LCD_ACCESS, LCD_READY} lcd_state_t;

  lcd_state_t       r_lcd_state;
  logic [LCW-1:0]   r_lcd_cnt;
  logic [2:0]       r_init_idx;
  logic [5:0]       r_col;
  logic [5:0]       w_col_nxt;
  logic             r_pend_valid;
  logic [7:0]       r_pend_cmd;
  logic             r_rs;
  logic             r_enable;
  logic [7:0]       r_data;
  logic [7:0]       w_pop_lcd;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h0C;
      3'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  always_comb begin
    w_pop_lcd                  = 8'h00;
    w_pop_lcd[DATA_BITS-1:0]   = w_pop_data;
  end

  assign w_col_nxt   = r_col + 6'd1;
  assign w_lcd_ready = (r_lcd_state == LCD_READY);

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_lcd_state  <= LCD_POWERUP;
      r_lcd_cnt    <= '0;
      r_init_idx   <= '0;
      r_col        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_cmd   <= 8'h00;
      r_rs         <= 1'b0;
      r_enable     <= 1'b0;
      r_data       <= 8'h00;
    end else begin
      case (r_lcd_state)
        LCD_POWERUP: begin
          if (r_lcd_cnt == LCW'(LCD_INIT_CYCLES - 1)) begin
            r_lcd_cnt   <= '0;
            r_rs        <= 1'b0;
            r_data      <= init_cmd(3'd0);
            r_init_idx  <= 3'd1;
            r_lcd_state <= LCD_ACCESS;
          end else begin
            r_lcd_cnt <= r_lcd_cnt + 1'b1;
          end
        end
        LCD_ACCESS: begin
          // Enable is high while the access counter reads 1..LCD_EN_CYCLES.
          r_enable <= (r_lcd_cnt < LCW'(LCD_EN_CYCLES));
          if (r_lcd_cnt == LCW'(LCD_ACCESS_CYCLES - 1)) begin
            r_lcd_cnt <= '0;
            if (r_init_idx != 3'd4) begin
              r_rs       <= 1'b0;
              r_data     <= init_cmd(r_init_idx);
              r_init_idx <= r_init_idx + 1'b1;
            end else if (r_pend_valid) begin
              r_rs         <= 1'b0;
              r_data       <= r_pend_cmd;
              r_pend_valid <= 1'b0;
            end else begin
              r_lcd_state <= LCD_READY;
            end
          end else begin
            r_lcd_cnt <= r_lcd_cnt + 1'b1;
          end
        end
        LCD_READY: begin
          if (w_pop) begin
            r_lcd_cnt   <= '0;
            r_rs        <= 1'b1;
            r_data      <= w_pop_lcd;
            r_lcd_state <= LCD_ACCESS;
            if (w_col_nxt == 6'd16) begin
              r_pend_valid <= 1'b1;
              r_pend_cmd   <= 8'hC0;
              r_col        <= w_col_nxt;
            end else if (w_col_nxt == 6'd32) begin
              r_pend_valid <= 1'b1;
              r_pend_cmd   <= 8'h01;
              r_col        <= '0;
            end else begin
              r_col <= w_col_nxt;
            end
          end
        end
        default: r_lcd_state <= LCD_POWERUP;
      endcase
    end
  end

  assign rs          = r_rs;
  assign rw          = 1'b0;
  assign enable      = r_enable;
  assign data_lcd    = r_data;
  assign o_dbg_state = {r_rx_state, w_tx_dbg, r_lcd_state};

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top with shortened baud and LCD timing; checks LCD writes, FIFO flags, reset.
`timescale 1ns/1ps
module tb_uart_top;
  localparam int BR_LIMIT = 4;
  localparam int BR_BITS  = 3;
  localparam int INIT_CYC = 12000;
  localparam int ACC_CYC  = 200;
  localparam int EN_CYC   = 25;
  localparam int BIT_CYC  = 16 * BR_LIMIT;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       tx;
  logic       rs;
  logic       rw;
  logic       enable;
  logic [7:0] data_lcd;
  logic       fifo_full;
  logic       fifo_empty;
  logic [5:0] dbg_state;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned rel_cyc = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  obs_q[$];
  int unsigned obs_t_q[$];
  logic [7:0]  tx_obs_q[$];
  logic        en_prev = 1'b0;
  int          rw_high = 0;
  int          tx_low = 0;

  uart_top #(
    .DATA_BITS(8), .STOP_BIT_TICK(16), .BR_LIMIT(BR_LIMIT), .BR_BITS(BR_BITS), .FIFO_EXP(4),
    .LCD_INIT_CYCLES(INIT_CYC), .LCD_ACCESS_CYCLES(ACC_CYC), .LCD_EN_CYCLES(EN_CYC)
  ) dut (
    .clk_50MHz(clk), .reset(reset), .rx(rx), .tx(tx), .rs(rs), .rw(rw), .enable(enable),
    .data_lcd(data_lcd), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- LCD bus monitor
  always @(negedge clk) begin
    if (enable && !en_prev) begin
      obs_q.push_back({rs, data_lcd});
      obs_t_q.push_back(cyc);
    end
    en_prev <= enable;
    if (rw !== 1'b0) rw_high <= rw_high + 1;
    if (tx !== 1'b1) tx_low <= tx_low + 1;
  end

`ifdef UART_ECHO_EN
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (BIT_CYC / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(negedge clk);
          b[i] = tx;
        end
        tx_obs_q.push_back(b);
        repeat (BIT_CYC) @(negedge clk);
      end
    end
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- driver tasks / scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_enable", enable, 1'b0);
    check("rst_rs", rs, 1'b0);
    check("rst_data_lcd", data_lcd, 8'h00);
    check("rst_fifo_empty", fifo_empty, 1'b1);
    check("rst_fifo_full", fifo_full, 1'b0);
    reset   = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic push_init_cmds();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic wait_writes(input int budget);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3 * ACC_CYC) @(negedge clk);
    check("write_count", obs_q.size(), exp_q.size());
  endtask

  task automatic check_init_timing(input string tag);
    if (obs_t_q.size() >= 4) begin
      check({tag, "_first_en"}, obs_t_q[0] - rel_cyc, INIT_CYC + 1);
      for (int i = 1; i < 4; i++)
        check($sformatf("%s_gap%0d", tag, i), obs_t_q[i] - obs_t_q[i-1], ACC_CYC);
    end
  endtask

  task automatic compare_writes(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
    obs_t_q.delete();
  endtask

  // ---------------------------------------------------------------- directed sequence
  initial begin
    logic [7:0] b41;
    reset = 1'b1;
    rx    = 1'b1;

    // Reset values, then 17 bytes during the power-up wait: 16 fill the FIFO, the 17th is dropped.
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      send_frame(8'h41 + 8'(i), 1'b1);
      if (i == 14) check("fifo_full_at15", fifo_full, 1'b0);
      if (i == 15) check("fifo_full_at16", fifo_full, 1'b1);
    end
    check("fifo_full_after17", fifo_full, 1'b1);
    check("fifo_empty_after17", fifo_empty, 1'b0);
    check("no_enable_in_wait", obs_q.size(), 0);
    push_init_cmds();
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'h41 + 8'(i)});
    exp_q.push_back({1'b0, 8'hC0});
    wait_writes(30000);
    check_init_timing("init");
    compare_writes("fill16");
    check("fifo_empty_drained", fifo_empty, 1'b1);

    // Three characters after init (columns 17..19).
    tx_obs_q.delete();
    send_frame(8'h31, 1'b1);
    send_frame(8'h32, 1'b1);
    send_frame(8'h33, 1'b1);
    exp_q.push_back({1'b1, 8'h31});
    exp_q.push_back({1'b1, 8'h32});
    exp_q.push_back({1'b1, 8'h33});
    wait_writes(5000);
    compare_writes("chars");
`ifdef UART_ECHO_EN
    check("echo_count", tx_obs_q.size(), 3);
    for (int i = 0; i < tx_obs_q.size(); i++)
      check($sformatf("echo[%0d]", i), tx_obs_q[i], 8'h31 + 8'(i));
`endif

    // Framing error: stop bit low, nothing must be pushed or written.
    send_frame(8'h55, 1'b0);
    check("frame_err_empty", fifo_empty, 1'b1);
    wait_writes(100);
    check("frame_err_empty_late", fifo_empty, 1'b1);
    compare_writes("frame_err");

    // Columns 20..32, then clear-display command and column restart.
    for (int i = 0; i < 13; i++) begin
      send_frame(8'h61 + 8'(i), 1'b1);
      exp_q.push_back({1'b1, 8'h61 + 8'(i)});
    end
    exp_q.push_back({1'b0, 8'h01});
    wait_writes(5000);
    compare_writes("col32");

    // Reset in the middle of 0x41: frame aborted, LCD re-initialises, next frame 0x42 is clean.
    b41 = 8'h41;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b41[i]);
    apply_reset();
    obs_q.delete();
    obs_t_q.delete();
    repeat (2 * BIT_CYC) @(negedge clk);
    send_frame(8'h42, 1'b1);
    check("rx42_pushed", fifo_empty, 1'b0);
    push_init_cmds();
    exp_q.push_back({1'b1, 8'h42});
    wait_writes(20000);
    check_init_timing("reinit");
    compare_writes("after_reset");

    check("rw_const", rw_high, 0);
`ifndef UART_ECHO_EN
    check("tx_const", tx_low, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
